smss_power_pipe: RTL and testbench
==================================

SMSS_POWER_PIPE -- requirements
Module: smss_power_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of parallel 6-bit S-box lanes (legal 1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the output beat counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered beat this cycle.
REQ-007 The block SHALL have port in_mode, input, 1 bit: 0 = forward map x^5, 1 = inverse map x^38; it travels with the beat.
REQ-008 The block SHALL have port in_data, input, 6*LANES bits: lane i is bits [6i+5:6i].
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result beat is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the presented beat.
REQ-011 The block SHALL have port out_data, output, 6*LANES bits: per-lane results in the same lane order as in_data.
REQ-012 The block SHALL have port beat_cnt, output, CNT_W bits: count of output beats accepted since reset.

Function
REQ-013 Each lane SHALL compute y = x^5 (mode 0) or y = x^38 (mode 1) in GF(2^6), polynomial basis, reduction polynomial z^6+z+1; bit 0 is the z^0 coefficient.
REQ-014 Because 5*38 = 1 mod 63, mode 1 SHALL be the exact inverse permutation of mode 0; 0 maps to 0 and 1 maps to 1 in both modes.
REQ-015 The pipeline SHALL have two register stages. Stage 1 registers x^4 and, per mode, x (mode 0) or x^2*x^32 (mode 1). Stage 2 registers the product of the stage-1 operands, giving x^5 or x^38.
REQ-016 Latency SHALL be exactly 2 cycles from an accepted input beat to out_valid, absent backpressure.
REQ-017 A transfer SHALL occur only on a cycle where valid and ready are both high; in_ready SHALL not depend combinationally on in_valid.
REQ-018 in_ready SHALL be high when stage 1 is empty, or when stage 1 can advance this cycle (stage 2 empty, or out_ready high).
REQ-019 While out_valid is high and out_ready is low, out_data SHALL hold stable.
REQ-020 Full throughput SHALL be sustained: with in_valid and out_ready held high, one beat per cycle with no bubbles.
REQ-021 With both stages full and out_ready low, in_ready SHALL be low; no beat SHALL be dropped or duplicated.
REQ-022 Mode SHALL be per beat: consecutive beats with different in_mode values SHALL each be processed in their own mode.
REQ-023 beat_cnt SHALL increment by 1 on every out_valid & out_ready cycle and SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 Lanes SHALL be fully independent; no lane's value affects another lane.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear out_valid, both stage-valid flags and beat_cnt to 0 and drive in_ready to 0.
REQ-026 While in reset, out_data SHALL read all-zero; datapath registers need no reset beyond valid gating.
REQ-027 In the first cycle after rst_n deasserts, in_ready SHALL be 1.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight beats; none SHALL appear after release.

Structure
REQ-029 A shared package SHALL hold the reduction-polynomial constant, the lane width (6), the mode encoding (MODE_FWD=0, MODE_INV=1) and the square/multiply functions.
REQ-030 One sub-module, smss_gf64_lane, SHALL implement a single lane's two-stage datapath. It SHALL contain no handshake logic and SHALL be instantiated LANES times by generate.

Verification
REQ-031 Exhaustive check: all 64 values per lane in mode 0, then mode 1, LANES=4, out_ready=1. Expected: matches the golden model; inputs 0x02 -> 0x20 in mode 0, and 0x20 -> 0x02 in mode 1.
REQ-032 Round trip: feed the mode-0 outputs back in mode 1. Expected: all 64 original values return in order, with 2-cycle latency each pass.
REQ-033 Backpressure: stream 10 beats, hold out_ready=0 for cycles 3-7. Expected: in_ready drops after 2 beats buffered, out_data stays stable, all 10 beats arrive in order, beat_cnt=10.
REQ-034 Mixed modes: alternate in_mode 0,1,0,1 with in_data=0x03 in every lane. Expected: each beat's outputs equal 0x03^5 or 0x03^38 according to its own mode.
REQ-035 Reset mid-stream: assert rst_n low with both stages full. Expected: out_valid=0 immediately, beat_cnt=0, in_ready=1 the cycle after release, no stale beat emitted.
REQ-036 Counter wrap: CNT_W=4, 17 accepted output beats. Expected: beat_cnt reads 1.

Source files
------------

// File: rtl/smss_power_pipe_pkg.sv
// Shared GF(2^6) constants and arithmetic for the power-map pipeline.
// Field is polynomial basis modulo z^6+z+1, bit 0 = z^0 coefficient.
package smss_power_pipe_pkg;

    localparam int unsigned LANE_W  = 6;
    localparam logic [6:0]  GF_POLY = 7'h43;
    localparam logic        MODE_FWD = 1'b0;
    localparam logic        MODE_INV = 1'b1;

    // Carry-less product followed by top-down reduction.
    function automatic logic [LANE_W-1:0] gf_mul(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ (11'(a) << i);
        end
        for (int i = 10; i >= 6; i--) begin
            if (p[i]) p = p ^ (11'(GF_POLY) << (i - 6));
        end
        return p[LANE_W-1:0];
    endfunction

    function automatic logic [LANE_W-1:0] gf_sq(input logic [LANE_W-1:0] a);
        return gf_mul(a, a);
    endfunction

endpackage

// File: rtl/smss_gf64_lane.sv
// One lane of the two-stage GF(2^6) power datapath: x^5 (fwd) or x^38 (inv).
// Pure datapath; load enables come from the handshake logic in the top.
module smss_gf64_lane
    import smss_power_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              i_ld1,
    input  logic              i_ld2,
    input  logic              i_mode,
    input  logic [LANE_W-1:0] i_x,
    output logic [LANE_W-1:0] o_y
);

    logic [LANE_W-1:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_op_b;
    logic [LANE_W-1:0] r_a, r_b, r_y;

    always_comb begin
        w_x2  = gf_sq(i_x);
        w_x4  = gf_sq(w_x2);
        w_x8  = gf_sq(w_x4);
        w_x16 = gf_sq(w_x8);
        w_x32 = gf_sq(w_x16);
        // x^38 = x^4 * (x^2 * x^32); x^5 = x^4 * x
        w_op_b = (i_mode == MODE_INV) ? gf_mul(w_x2, w_x32) : i_x;
    end

    always_ff @(posedge clk) begin
        if (i_ld1) begin
            r_a <= w_x4;
            r_b <= w_op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (i_ld2) r_y <= gf_mul(r_a, r_b);
    end

    assign o_y = r_y;

endmodule

// File: rtl/smss_power_pipe.sv
// Multi-lane GF(2^6) power-map pipeline with valid/ready handshake and
// an accepted-output beat counter.
module smss_power_pipe
    import smss_power_pipe_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [LANE_W*LANES-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]          beat_cnt
);

    logic                    r_s1_valid, r_s2_valid;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic                    w_s1_ready, w_s2_ready, w_acc, w_adv, w_out_fire;
    logic [LANE_W*LANES-1:0] w_lane_y;

    always_comb begin
        w_s2_ready = !r_s2_valid || out_ready;
        w_s1_ready = !r_s1_valid || w_s2_ready;
        // Reset gating keeps in_ready low while rst_n is asserted.
        in_ready   = rst_n && w_s1_ready;
        w_acc      = in_valid && in_ready;
        w_adv      = r_s1_valid && w_s2_ready;
        w_out_fire = r_s2_valid && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_s1_valid <= w_acc || (r_s1_valid && !w_s2_ready);
            r_s2_valid <= w_adv || (r_s2_valid && !out_ready);
            if (w_out_fire) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        smss_gf64_lane u_lane (
            .clk    (clk),
            .i_ld1  (w_acc),
            .i_ld2  (w_adv),
            .i_mode (in_mode),
            .i_x    (in_data[LANE_W*g +: LANE_W]),
            .o_y    (w_lane_y[LANE_W*g +: LANE_W])
        );
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_valid ? w_lane_y : '0;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_smss_power_pipe.sv
// Scoreboard bench for smss_power_pipe: reference GF(2^6) model, handshake
// model of in_ready, output stability under stall, counter and reset checks.
module tb_smss_power_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned W     = 6 * LANES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_mode = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] beat_cnt;

    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic [W-1:0]     sb_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             hold_v = 1'b0;
    logic [W-1:0]     hold_d = '0;

    smss_power_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Shift-and-add multiply with per-step reduction by z^6 = z + 1.
    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r, t;
        r = '0;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ t;
            t = {t[4:0], 1'b0} ^ (t[5] ? 6'h03 : 6'h00);
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < e; i++) r = ref_mul(r, x);
        return r;
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic m);
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[6*l +: 6] = ref_pow(d[6*l +: 6], m ? 38 : 5);
        return r;
    endfunction

    function automatic logic [W-1:0] pattern(input int v);
        logic [W-1:0] d;
        for (int l = 0; l < LANES; l++) d[6*l +: 6] = 6'((v + 16 * l) % 64);
        return d;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            chk("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
            chk("in_ready", 32'(in_ready), 32'((sb_q.size() < 2) || out_ready));
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(hold_d));
            end
            if (out_valid && sb_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
            if (out_valid && out_ready && sb_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(sb_q.pop_front()));
                exp_cnt = exp_cnt + 1'b1;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (in_valid && in_ready) sb_q.push_back(ref_beat(in_data, in_mode));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
        exp_cnt = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic m);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        do_reset();

        // Two-cycle latency and the 0x02 <-> 0x20 anchor points.
        send_beat({LANES{6'h02}}, 1'b0);
        chk("lat_early_fwd", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_fwd", 32'(out_valid), 32'd1);
        chk("fwd_02", 32'(out_data), 32'({LANES{6'h20}}));
        wait_drain();
        send_beat({LANES{6'h20}}, 1'b1);
        chk("lat_early_inv", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_inv", 32'(out_valid), 32'd1);
        chk("inv_20", 32'(out_data), 32'({LANES{6'h02}}));
        wait_drain();

        // Exhaustive per lane, both modes, with throughput measured.
        for (int m = 0; m < 2; m++) begin
            t0 = cyc;
            for (int v = 0; v < 64; v++) send_beat(pattern(v), m[0]);
            chk("throughput", 32'(cyc - t0), 32'd64);
            wait_drain();
        end

        // Round trip: forward images sent back through the inverse map.
        for (int v = 0; v < 64; v++) send_beat(ref_beat(pattern(v), 1'b0), 1'b1);
        wait_drain();

        // Mixed per-beat modes.
        for (int i = 0; i < 4; i++) send_beat({LANES{6'h03}}, i[0]);
        wait_drain();

        // Backpressure: 10 beats, out_ready low for cycles 3-7.
        do_reset();
        fork
            for (int i = 0; i < 10; i++) send_beat(pattern(i * 5 + 1), i[1]);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_beat_cnt", 32'(beat_cnt), 32'd10);

        // Reset with both stages full.
        do_reset();
        out_ready = 1'b0;
        send_beat(pattern(7), 1'b0);
        send_beat(pattern(9), 1'b1);
        @(negedge clk);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_valid", 32'(out_valid), 32'd0);

        // Counter wrap with CNT_W = 4.
        do_reset();
        for (int i = 0; i < 17; i++) send_beat(pattern(i), 1'b0);
        wait_drain();
        chk("cnt_wrap", 32'(beat_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
